// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard and its per-register entries.
package hazard_pkg;

    localparam int NREGS_DEF = 32;

    typedef logic [4:0] reg_idx_t;

    // RV32I major opcodes that the surrounding decode logic classifies on.
    localparam logic [6:0] LOAD   = 7'b000_0011;
    localparam logic [6:0] STORE  = 7'b010_0011;
    localparam logic [6:0] JAL    = 7'b110_1111;
    localparam logic [6:0] JALR   = 7'b110_0111;
    localparam logic [6:0] B_TYPE = 7'b110_0011;
    localparam logic [6:0] LUI    = 7'b011_0111;
    localparam logic [6:0] AUIPC  = 7'b001_0111;

endpackage

// File: rtl/hsb_entry.sv
// One register's pending-write counter and load-age tracker, with saturation and sticky error.
module hsb_entry #(
    parameter int CNT_W    = 2,
    parameter int LOAD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             load_set,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic [1:0]       age,
    output logic             err
);

    localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W:0] up;
    logic [CNT_W:0] dec_w;
    logic [CNT_W:0] diff;
    logic           under;
    logic           over;
    logic [1:0]     age_next;

    // inc and dec are applied in a single step so issue+writeback in one cycle nets to zero.
    always_comb begin
        up       = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
        dec_w    = (CNT_W + 1)'(dec);
        diff     = up - dec_w;
        under    = 1'b0;
        over     = 1'b0;
        cnt_next = cnt;
        if (up < dec_w) begin
            under    = 1'b1;
            cnt_next = '0;
        end else if (diff > MAX) begin
            over     = 1'b1;
            cnt_next = MAX[CNT_W-1:0];
        end else begin
            cnt_next = diff[CNT_W-1:0];
        end
    end

    always_comb begin
        age_next = age;
        if (load_set) begin
            age_next = 2'(LOAD_LAT);
        end else if ((dec != 2'd0) && (cnt_next == '0)) begin
            age_next = 2'd0;
        end else if (age != 2'd0) begin
            age_next = age - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            age <= 2'd0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_next;
            age <= age_next;
            err <= err | under | over;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register and answers decode operand queries.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int CNT_W    = 2,
    parameter int LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_regwen,
    input  logic        issue_is_load,
    input  logic        stall_in,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        kill_valid,
    input  logic [4:0]  kill_rd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    input  logic        q_use_rs1,
    input  logic        q_use_rs2,
    output logic        busy1,
    output logic        busy2,
    output logic        load_busy1,
    output logic        load_busy2,
    output logic        stall_req,
    output logic [5:0]  outstanding,
    output logic        err,
    output logic [15:0] stall_cycles
);

    logic [CNT_W-1:0] cnt_arr      [NREGS];
    logic [CNT_W-1:0] cnt_next_arr [NREGS];
    logic [1:0]       age_arr      [NREGS];
    logic [NREGS-1:0] err_vec;
    logic             issue_cnt;
    logic [5:0]       outstanding_next;

    // Slot 0 is a constant-zero x0 so the read muxes need no special case.
    assign cnt_arr[0]      = '0;
    assign cnt_next_arr[0] = '0;
    assign age_arr[0]      = 2'd0;
    assign err_vec[0]      = 1'b0;

    assign issue_cnt = issue_valid & ~stall_in & issue_regwen & (issue_rd != 5'd0);

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        logic       inc;
        logic       wb_hit;
        logic       kill_hit;
        logic [1:0] dec;

        assign inc      = issue_cnt & (issue_rd == reg_idx_t'(r));
        assign wb_hit   = wb_valid & (wb_rd == reg_idx_t'(r));
        assign kill_hit = kill_valid & (kill_rd == reg_idx_t'(r));
        assign dec      = {1'b0, wb_hit} + {1'b0, kill_hit};

        hsb_entry #(
            .CNT_W    (CNT_W),
            .LOAD_LAT (LOAD_LAT)
        ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .inc      (inc),
            .load_set (inc & issue_is_load),
            .dec      (dec),
            .cnt      (cnt_arr[r]),
            .cnt_next (cnt_next_arr[r]),
            .age      (age_arr[r]),
            .err      (err_vec[r])
        );
    end

    assign busy1      = (cnt_arr[q_rs1] != '0);
    assign busy2      = (cnt_arr[q_rs2] != '0);
    assign load_busy1 = (age_arr[q_rs1] != 2'd0);
    assign load_busy2 = (age_arr[q_rs2] != 2'd0);
    assign stall_req  = (q_use_rs1 & load_busy1) | (q_use_rs2 & load_busy2);
    assign err        = |err_vec;

    always_comb begin
        outstanding_next = 6'd0;
        for (int r = 1; r < NREGS; r++) begin
            outstanding_next = outstanding_next + 6'(cnt_next_arr[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding  <= 6'd0;
            stall_cycles <= 16'd0;
        end else begin
            outstanding <= outstanding_next;
            if (stall_req && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule
